counter_sched: RTL and testbench

- Controller that shares one free-running W-bit up-counter (clk/rst/en/count style) among N requesters.
- Each requester asks for a timed slot of `len` counts. The block arbitrates round-robin, clears the counter, and enables it until count equals the requested length. It then pulses done to the owner.
- Sits between requester logic and a single counter instance; it drives the counter's clear and enable and observes its count.

---
 rtl/counter_sched.sv | 143 ++++++++++++++
 tb/tb_counter_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// counter_sched: shares one external free-running up-counter among N requesters.
//
// A requester raises req[i] with a terminal count on len[i*W +: W]. Requests are
// arbitrated round-robin. The winner is granted, the counter is cleared for one
// cycle and then enabled until count equals the latched length. A one-cycle done
// pulse then goes to the owner. Dropping req while running aborts the slot with
// no done.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-low
//   req      per-requester request level, held until done or abort
//   len      per-requester terminal count, requester i at bits [i*W +: W]
//   gnt      one-hot grant, registered; zero when idle
//   done     one-cycle completion pulse to the owner, registered
//   busy     high whenever a slot is in progress
//   cnt_clr  active-high clear to the counter, also held high during reset
//   cnt_en   counter enable
//   count    counter value, registered inside the counter
module counter_sched #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] len,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic           busy,
    output logic           cnt_clr,
    output logic           cnt_en,
    input  logic [W-1:0]   count
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic [W-1:0]      len_q, len_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [N-1:0]      done_q, done_d;

    // Round-robin pick: first set request at or above rr_q, wrapping modulo N.
    logic              found;
    logic [IdxW-1:0]   pick;
    logic [W-1:0]      pick_len;
    int unsigned       cand;

    always_comb begin
        found    = 1'b0;
        pick     = '0;
        pick_len = '0;
        cand     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(rr_q) + i) % N;
            if (!found && req[cand[IdxW-1:0]]) begin
                found    = 1'b1;
                pick     = cand[IdxW-1:0];
                pick_len = W'(len >> (cand * W));
            end
        end
    end

    logic [IdxW-1:0] idx_inc;
    assign idx_inc = (32'(idx_q) == N - 1) ? '0 : idx_q + 1'b1;

    logic at_term;
    assign at_term = (count == len_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        len_d   = len_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        cnt_en  = 1'b0;
        cnt_clr = !rst;
        busy    = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StClear;
                    idx_d   = pick;
                    len_d   = pick_len;
                    gnt_d   = N'(1) << pick;
                end
            end
            StClear: begin
                cnt_clr = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                // Gating on at_term stops the counter exactly at len_q, never wrapping.
                cnt_en = req[idx_q] && !at_term;
                if (at_term) begin
                    state_d = StDone;
                    done_d  = gnt_q;
                end else if (!req[idx_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    rr_d    = idx_inc;
                end
            end
            StDone: begin
                state_d = StIdle;
                gnt_d   = '0;
                rr_d    = idx_inc;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            rr_q    <= '0;
            len_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            len_q   <= len_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed scenarios plus randomized traffic for counter_sched.
// A bench-side counter is driven by the DUT's cnt_clr/cnt_en. A slot-level
// reference model (owner, slot age, latched length, pointer) predicts every
// output each cycle.
module tb_counter_sched;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] len = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic           cnt_clr;
    logic           cnt_en;
    logic [W-1:0]   count;

    counter_sched #(.N(N), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len     (len),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .count   (count)
    );

    always #5 clk = ~clk;

    // The shared counter the block controls.
    always_ff @(posedge clk) begin
        if (cnt_clr) count <= '0;
        else if (cnt_en) count <= count + 1'b1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = none), age (0 = clear cycle), finish = done cycle.
    int           m_owner = -1;
    int           m_ptr   = 0;
    int           m_age   = 0;
    bit           m_finish = 1'b0;
    logic [W-1:0] m_len   = '0;
    logic [W-1:0] m_cnt   = '0;

    task automatic model_cycle();
        logic [N-1:0] eg, ed;
        logic         ebusy, eclr, een;
        logic [W-1:0] cnt_old;
        eg    = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        ed    = m_finish ? eg : '0;
        ebusy = (m_owner >= 0);
        eclr  = !rst || (m_owner >= 0 && m_age == 0);
        een   = (m_owner >= 0) && (m_age >= 1) && !m_finish && req[m_owner] && (m_cnt != m_len);
        check("gnt", 32'(gnt), 32'(eg));
        check("done", 32'(done), 32'(ed));
        check("busy", 32'(busy), 32'(ebusy));
        check("cnt_clr", 32'(cnt_clr), 32'(eclr));
        check("cnt_en", 32'(cnt_en), 32'(een));
        check("count", 32'(count), 32'(m_cnt));
        cnt_old = m_cnt;
        if (eclr) m_cnt = '0;
        else if (een) m_cnt = m_cnt + 1'b1;
        if (!rst) begin
            m_owner = -1; m_ptr = 0; m_age = 0; m_finish = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (m_owner < 0 && req[j]) begin
                    m_owner = j;
                    m_len   = len[j*W +: W];
                    m_age   = 0;
                end
            end
        end else if (m_finish) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1; m_finish = 1'b0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (cnt_old == m_len) begin
            m_finish = 1'b1;
        end else if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1;
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] l);
        @(posedge clk);
        #1;
        rst = r; req = q; len = l;
        @(negedge clk);
        model_cycle();
    endtask

    task automatic drain();
        for (int k = 0; k < 6; k++) step(1'b1, '0, len);
    endtask

    // Hold req[i] until done (bounded); report done latency and count at done.
    task automatic run_single(input int i, input logic [W-1:0] l_val, output int lat,
                              output logic [W-1:0] cnt_at_done);
        logic [N*W-1:0] l;
        logic [N-1:0]   q;
        l = '0; l[i*W +: W] = l_val;
        q = '0; q[i] = 1'b1;
        lat = -1; cnt_at_done = '0;
        step(1'b1, q, l);
        l[i*W +: W] = ~l_val;  // must be ignored once latched
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            step(1'b1, q, l);
            if (done[i]) begin
                lat = k; cnt_at_done = count;
            end
        end
        step(1'b1, '0, l);
    endtask

    initial begin
        int               lat;
        logic [W-1:0]     cd;
        logic [N-1:0]     gseq[$];
        logic [N-1:0]     prev_g;
        logic [N-1:0]     q;
        logic [N*W-1:0]   l;
        logic [N-1:0]     dseen;
        bit               seen;

        // 1: reset held with all requesting, then release.
        for (int k = 0; k < 3; k++) step(1'b0, 4'b1111, '0);
        step(1'b1, 4'b1111, '0);
        step(1'b1, 4'b1111, '0);
        check("t1_first_gnt", 32'(gnt), 32'h1);
        drain();

        // 2: len=5 on requester 2, done at t+8 with count held at 5.
        run_single(2, 4'd5, lat, cd);
        check("t2_done_lat", 32'(lat), 32'd8);
        check("t2_count_at_done", 32'(cd), 32'd5);
        drain();

        // 3: two requesters holding with len 3, round-robin order 0,1,0.
        gseq.delete();
        prev_g = '0;
        for (int k = 0; k < 30; k++) begin
            step(1'b1, 4'b0011, {4{4'd3}});
            if (gnt != '0 && prev_g == '0) gseq.push_back(gnt);
            prev_g = gnt;
        end
        check("t3_ngrants_ge3", 32'(gseq.size() >= 3), 32'd1);
        if (gseq.size() >= 3) begin
            check("t3_grant0", 32'(gseq[0]), 32'h1);
            check("t3_grant1", 32'(gseq[1]), 32'h2);
            check("t3_grant2", 32'(gseq[2]), 32'h1);
        end
        drain();

        // 4: zero length completes at t+3.
        run_single(1, 4'd0, lat, cd);
        check("t4_done_lat", 32'(lat), 32'd3);
        drain();

        // 5: maximum length runs to 15 without wrapping.
        run_single(0, 4'd15, lat, cd);
        check("t5_done_lat", 32'(lat), 32'd18);
        check("t5_count_at_done", 32'(cd), 32'd15);
        drain();

        // 6a: abort requester 3 mid-run, pointer wraps to 0.
        l = '0; l[3*W +: W] = 4'd9;
        seen = 1'b0;
        step(1'b1, 4'b1000, l);
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1'b1, 4'b1000, l);
            if (count == 4'd2) seen = 1'b1;
        end
        check("t6a_reached_2", 32'(seen), 32'd1);
        step(1'b1, 4'b0000, l);
        check("t6a_no_done", 32'(done), 32'h0);
        step(1'b1, 4'b0000, l);
        check("t6a_idle", 32'(busy), 32'd0);
        step(1'b1, 4'b1111, l);
        step(1'b1, 4'b1111, l);
        check("t6a_next_gnt", 32'(gnt), 32'h1);
        drain();

        // 6b: reset mid-run.
        l = '0; l[1*W +: W] = 4'd9;
        seen = 1'b0;
        step(1'b1, 4'b0010, l);
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1'b1, 4'b0010, l);
            if (count == 4'd4) seen = 1'b1;
        end
        check("t6b_reached_4", 32'(seen), 32'd1);
        step(1'b0, 4'b0010, l);
        check("t6b_clr_in_rst", 32'(cnt_clr), 32'd1);
        step(1'b1, 4'b0000, l);
        check("t6b_idle_gnt", 32'(gnt), 32'h0);
        check("t6b_no_done", 32'(done), 32'h0);
        drain();

        // Randomized traffic with occasional aborts, len churn and resets.
        q = '0; l = len; dseen = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (q[i]) begin
                    if (dseen[i] && $urandom_range(3) != 0) q[i] = 1'b0;
                    else if ($urandom_range(39) == 0) q[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    q[i] = 1'b1;
                end
                if ($urandom_range(7) == 0) l[i*W +: W] = W'($urandom);
            end
            step(($urandom_range(199) != 0), q, l);
            dseen = done;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
